// File: rtl/input_buffer_if.sv
// Bundles the AXI4-Stream slave side and the array-side FIFO port of input_buffer.
// The block uses the slave modport; the upstream source and array consumer use master.
interface input_buffer_if #(
    parameter int unsigned DEPTH = 4
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic          s_axis_valid;
    logic          s_axis_ready;
    logic [31:0]   s_axis_data;
    logic          s_axis_last;

    logic          out_valid;
    logic          out_ready;
    logic [127:0]  out_data;
    logic          out_last;
    logic [CW-1:0] count;

    modport slave (
        input  s_axis_valid,
        input  s_axis_data,
        input  s_axis_last,
        input  out_ready,
        output s_axis_ready,
        output out_valid,
        output out_data,
        output out_last,
        output count
    );

    modport master (
        output s_axis_valid,
        output s_axis_data,
        output s_axis_last,
        output out_ready,
        input  s_axis_ready,
        input  out_valid,
        input  out_data,
        input  out_last,
        input  count
    );
endinterface

// File: rtl/input_buffer.sv
// Packs 32-bit AXI4-Stream beats into 128-bit words (short packets zero-padded)
// and queues them in a first-word-fall-through FIFO of DEPTH entries.
module input_buffer #(
    parameter int unsigned DEPTH = 4
) (
    input  logic          axi_clk,
    input  logic          axi_rst,
    input_buffer_if.slave bus
);
    localparam int unsigned AW      = $clog2(DEPTH);
    localparam int unsigned CW      = AW + 1;
    localparam int unsigned LANE_W  = 32;
    localparam int unsigned WORD_W  = 4 * LANE_W;
    localparam int unsigned ASM_W   = 3 * LANE_W;
    localparam int unsigned ENTRY_W = WORD_W + 1;

    logic [1:0]         r_lane;
    logic [ASM_W-1:0]   r_asm;
    logic [ENTRY_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]      r_head;
    logic [AW-1:0]      r_tail;
    logic [CW-1:0]      r_count;

    logic               w_ready;
    logic               w_accept;
    logic               w_complete;
    logic               w_pop;
    logic [WORD_W-1:0]  w_word;
    logic [ASM_W-1:0]   w_asm_next;

    // Handshake decode; ready depends only on the stored word count.
    always_comb begin
        w_ready    = (r_count < CW'(DEPTH));
        w_accept   = bus.s_axis_valid & w_ready;
        w_complete = w_accept & ((r_lane == 2'd3) | bus.s_axis_last);
        w_pop      = (r_count != '0) & bus.out_ready;
    end

    // Lanes above r_lane are always zero in r_asm, which gives the padding for free.
    always_comb begin
        w_word     = {{LANE_W{1'b0}}, r_asm};
        w_asm_next = r_asm;
        case (r_lane)
            2'd0: begin
                w_word[31:0]     = bus.s_axis_data;
                w_asm_next[31:0] = bus.s_axis_data;
            end
            2'd1: begin
                w_word[63:32]     = bus.s_axis_data;
                w_asm_next[63:32] = bus.s_axis_data;
            end
            2'd2: begin
                w_word[95:64]     = bus.s_axis_data;
                w_asm_next[95:64] = bus.s_axis_data;
            end
            default: begin
                w_word[127:96] = bus.s_axis_data;
            end
        endcase
    end

    // Beat assembly: lane counter and partially filled word.
    always_ff @(posedge axi_clk) begin
        if (axi_rst) begin
            r_lane <= 2'd0;
            r_asm  <= '0;
        end else if (w_accept) begin
            if (w_complete) begin
                r_lane <= 2'd0;
                r_asm  <= '0;
            end else begin
                r_lane <= r_lane + 2'd1;
                r_asm  <= w_asm_next;
            end
        end
    end

    // FIFO storage and pointers; power-of-two DEPTH makes the pointers wrap naturally.
    always_ff @(posedge axi_clk) begin
        if (axi_rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_complete) begin
                r_mem[r_tail] <= {bus.s_axis_last, w_word};
                r_tail        <= r_tail + AW'(1);
            end
            if (w_pop) begin
                r_head <= r_head + AW'(1);
            end
            case ({w_complete, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign bus.s_axis_ready = w_ready;
    assign bus.out_valid    = (r_count != '0);
    assign bus.out_data     = r_mem[r_head][WORD_W-1:0];
    assign bus.out_last     = r_mem[r_head][WORD_W];
    assign bus.count        = r_count;

endmodule

// File: tb/tb_input_buffer.sv
// Bench for input_buffer: directed scenarios plus random traffic, checked every cycle
// against a queue-based model of packets and stored words.
module tb_input_buffer;
    localparam int unsigned DEPTH = 4;

    logic axi_clk = 1'b0;
    logic axi_rst = 1'b1;

    input_buffer_if #(.DEPTH(DEPTH)) bus ();

    input_buffer #(.DEPTH(DEPTH)) dut (
        .axi_clk (axi_clk),
        .axi_rst (axi_rst),
        .bus     (bus)
    );

    always #5 axi_clk = ~axi_clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [128:0] exp_q[$];
    logic [31:0]  beats[$];

    task automatic check(input string tag, input logic [128:0] obs, input logic [128:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        check("ready", 129'(bus.s_axis_ready), 129'(exp_q.size() < int'(DEPTH)));
        check("valid", 129'(bus.out_valid), 129'(exp_q.size() != 0));
        check("count", 129'(bus.count), 129'(exp_q.size()));
        if (exp_q.size() != 0)
            check("head", {bus.out_last, bus.out_data}, exp_q[0]);
    endtask

    // One clock: drive inputs, advance model on the edge, then compare.
    task automatic step(input logic v, input logic [31:0] d, input logic l,
                        input logic ordy, input logic rst);
        logic         acc;
        logic         pop;
        logic [128:0] w;
        bus.s_axis_valid = v;
        bus.s_axis_data  = d;
        bus.s_axis_last  = l;
        bus.out_ready    = ordy;
        axi_rst          = rst;
        acc = v && (exp_q.size() < int'(DEPTH));
        pop = ordy && (exp_q.size() != 0);
        @(posedge axi_clk);
        if (rst) begin
            exp_q.delete();
            beats.delete();
        end else begin
            if (pop) void'(exp_q.pop_front());
            if (acc) begin
                beats.push_back(d);
                if (l || beats.size() == 4) begin
                    w = '0;
                    for (int i = 0; i < beats.size(); i++) w[32*i +: 32] = beats[i];
                    w[128] = l;
                    exp_q.push_back(w);
                    beats.delete();
                end
            end
        end
        #1;
        check_outputs();
    endtask

    initial begin
        bus.s_axis_valid = 1'b0;
        bus.s_axis_data  = '0;
        bus.s_axis_last  = 1'b0;
        bus.out_ready    = 1'b0;

        // Reset state
        step(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b1, 1'b1);
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        check("rst_data", {bus.out_last, bus.out_data}, 129'h0);
        check("rst_ready", 129'(bus.s_axis_ready), 129'h1);

        // Full four-beat packet
        step(1'b1, 32'h1111_1111, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h2222_2222, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h3333_3333, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h4444_4444, 1'b1, 1'b0, 1'b0);
        check("full_pkt", {bus.out_last, bus.out_data},
              {1'b1, 128'h44444444_33333333_22222222_11111111});
        check("full_pkt_cnt", 129'(bus.count), 129'd1);
        step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);

        // Short packet, then the next packet must start in lane 0
        step(1'b1, 32'hAAAA_0001, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'hAAAA_0002, 1'b1, 1'b0, 1'b0);
        check("short_pkt", {bus.out_last, bus.out_data},
              {1'b1, 128'h00000000_00000000_AAAA0002_AAAA0001});
        step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 32'hBBBB_0001, 1'b1, 1'b0, 1'b0);
        check("lane0_after", {bus.out_last, bus.out_data}, {1'b1, 128'hBBBB0001});
        step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);

        // Fill to full, hold the 17th beat, release with one pop
        for (int i = 0; i < 16; i++) step(1'b1, 32'(32'hC000_0000 + i), 1'b0, 1'b0, 1'b0);
        check("full_cnt", 129'(bus.count), 129'(DEPTH));
        check("full_ready", 129'(bus.s_axis_ready), 129'h0);
        step(1'b1, 32'hC000_0010, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'hC000_0010, 1'b0, 1'b0, 1'b0);
        check("held_cnt", 129'(bus.count), 129'(DEPTH));
        step(1'b1, 32'hC000_0010, 1'b0, 1'b1, 1'b0);
        check("pop_cnt", 129'(bus.count), 129'(DEPTH - 1));
        step(1'b1, 32'hC000_0010, 1'b0, 1'b0, 1'b0);

        // Streaming through a full FIFO with the consumer always ready
        for (int i = 0; i < 12 * int'(DEPTH); i++)
            step(1'b1, 32'(32'hD000_0000 + i), 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);

        // Reset mid-packet with stored words
        for (int i = 0; i < 10; i++) step(1'b1, 32'(32'hE000_0000 + i), 1'b0, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        check("mid_rst_cnt", 129'(bus.count), 129'h0);
        check("mid_rst_valid", 129'(bus.out_valid), 129'h0);
        check("mid_rst_data", 129'(bus.out_data), 129'h0);
        check("mid_rst_ready", 129'(bus.s_axis_ready), 129'h1);
        step(1'b1, 32'h0000_0005, 1'b1, 1'b0, 1'b0);
        check("post_rst_beat", {bus.out_last, bus.out_data}, {1'b1, 128'h5});
        step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);

        // Random traffic with occasional reset
        for (int i = 0; i < 3000; i++) begin
            step(1'b1 && ($urandom_range(0, 9) < 7),
                 32'($urandom()),
                 1'b1 && ($urandom_range(0, 3) == 0),
                 1'b1 && ($urandom_range(0, 1) == 1),
                 1'b1 && ($urandom_range(0, 99) == 0));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
